// File: rtl/sdram_row_arbiter.sv
// sdram_row_arbiter: shares one SDRAM row-burst controller between the
// display read path and the frame write path. It latches the winning
// request, pulses the controller start with row/direction, waits for the
// controller Done level to go low then high, and returns a one-cycle Done
// strobe to the owner.
//
// Optional feature macro: ARB_WATCHDOG_EN
//   defined   -> per-operation watchdog with a sticky Timeout flag
//   undefined -> no watchdog, Timeout tied low, WAIT states wait forever
module sdram_row_arbiter #(
  parameter int START_CYCLES    = 2,
  parameter int MAX_READ_STREAK = 4,
  parameter int TIMEOUT_CYCLES  = 1023
) (
  input  logic       CLK,
  input  logic       Reset_N,
  input  logic       Rd_Req,
  input  logic [8:0] Rd_Row,
  output logic       Rd_Grant,
  output logic       Rd_Done,
  input  logic       Wr_Req,
  input  logic [8:0] Wr_Row,
  output logic       Wr_Grant,
  output logic       Wr_Done,
  output logic       Mem_Start,
  output logic [8:0] Mem_Row,
  output logic       Mem_Write,
  input  logic       Mem_Done,
  output logic       Busy,
  output logic       Timeout
);

  localparam int SC_W = $clog2(START_CYCLES + 1);
  localparam int ST_W = $clog2(MAX_READ_STREAK + 1);
  localparam logic [SC_W-1:0] START_LAST = SC_W'(START_CYCLES - 1);
  localparam logic [ST_W-1:0] STREAK_MAX = ST_W'(MAX_READ_STREAK);

  // Reject configurations the counters cannot represent.
  if (START_CYCLES < 1 || MAX_READ_STREAK < 1 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
    $error("sdram_row_arbiter: START_CYCLES, MAX_READ_STREAK and TIMEOUT_CYCLES must be >= 1");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_WAIT_LOW,
    S_WAIT_HIGH,
    S_FINISH
  } state_t;

  state_t            state_q, state_d;
  logic [SC_W-1:0]   start_cnt_q;
  logic [ST_W-1:0]   streak_q;
  logic              rd_own_q, wr_own_q;
  logic [8:0]        mem_row_q;
  logic              mem_write_q;
  logic              mem_start_q;
  logic              grant_rd, grant_wr;
  logic              rd_wins;

  // Read wins a tie unless it has already taken its allowed streak.
  assign rd_wins = Rd_Req && (!Wr_Req || (streak_q != STREAK_MAX));

`ifdef ARB_WATCHDOG_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);
  logic [WD_W-1:0] wd_cnt_q;
  logic            timeout_q;
  logic            wd_expire;
`endif

  // Next-state logic and grant decisions.
  always_comb begin
    state_d  = state_q;
    grant_rd = 1'b0;
    grant_wr = 1'b0;
`ifdef ARB_WATCHDOG_EN
    wd_expire = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (rd_wins) begin
          grant_rd = 1'b1;
          state_d  = S_START;
        end else if (Wr_Req) begin
          grant_wr = 1'b1;
          state_d  = S_START;
        end
      end
      S_START:     if (start_cnt_q == START_LAST) state_d = S_WAIT_LOW;
      // Done is still high from the previous burst until the start is seen.
      S_WAIT_LOW:  if (!Mem_Done) state_d = S_WAIT_HIGH;
      S_WAIT_HIGH: if (Mem_Done) state_d = S_FINISH;
      S_FINISH:    state_d = S_IDLE;
      default:     state_d = S_IDLE;
    endcase
`ifdef ARB_WATCHDOG_EN
    if ((state_q == S_WAIT_LOW || state_q == S_WAIT_HIGH) && (wd_cnt_q == WD_LAST)) begin
      wd_expire = 1'b1;
      state_d   = S_FINISH;
    end
`endif
  end

  // State register, start-pulse timing and read-streak tracking.
  always_ff @(posedge CLK or negedge Reset_N) begin
    if (!Reset_N) begin
      state_q     <= S_IDLE;
      start_cnt_q <= '0;
      streak_q    <= '0;
      mem_start_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      mem_start_q <= (state_d == S_START);
      if (grant_rd || grant_wr)
        start_cnt_q <= '0;
      else if (state_q == S_START)
        start_cnt_q <= start_cnt_q + SC_W'(1);
      if (grant_wr)
        streak_q <= '0;
      else if (grant_rd)
        streak_q <= !Wr_Req ? '0 :
                    (streak_q == STREAK_MAX) ? streak_q : streak_q + ST_W'(1);
    end
  end

  // Ownership plus row/direction latched at grant, held until IDLE.
  always_ff @(posedge CLK or negedge Reset_N) begin
    if (!Reset_N) begin
      rd_own_q    <= 1'b0;
      wr_own_q    <= 1'b0;
      mem_row_q   <= '0;
      mem_write_q <= 1'b0;
    end else if (grant_rd || grant_wr) begin
      rd_own_q    <= grant_rd;
      wr_own_q    <= grant_wr;
      mem_row_q   <= grant_wr ? Wr_Row : Rd_Row;
      mem_write_q <= grant_wr;
    end else if (state_q == S_FINISH) begin
      rd_own_q <= 1'b0;
      wr_own_q <= 1'b0;
    end
  end

`ifdef ARB_WATCHDOG_EN
  // Watchdog: restarts at each grant, counts WAIT cycles, sticky timeout.
  always_ff @(posedge CLK or negedge Reset_N) begin
    if (!Reset_N) begin
      wd_cnt_q  <= '0;
      timeout_q <= 1'b0;
    end else begin
      if (grant_rd || grant_wr)
        wd_cnt_q <= '0;
      else if (state_q == S_WAIT_LOW || state_q == S_WAIT_HIGH)
        wd_cnt_q <= wd_cnt_q + WD_W'(1);
      if (wd_expire)
        timeout_q <= 1'b1;
    end
  end

  assign Timeout = timeout_q;
`else
  assign Timeout = 1'b0;
`endif

  assign Rd_Grant  = rd_own_q;
  assign Wr_Grant  = wr_own_q;
  assign Rd_Done   = (state_q == S_FINISH) && rd_own_q;
  assign Wr_Done   = (state_q == S_FINISH) && wr_own_q;
  assign Mem_Start = mem_start_q;
  assign Mem_Row   = mem_row_q;
  assign Mem_Write = mem_write_q;
  assign Busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_sdram_row_arbiter.sv
// Directed bench for sdram_row_arbiter with a small behavioural model of
// the SDRAM row-burst controller's Done level.
module tb_sdram_row_arbiter;

  logic       clk = 1'b0;
  logic       Reset_N = 1'b0;
  logic       Rd_Req = 1'b0;
  logic [8:0] Rd_Row = '0;
  logic       Wr_Req = 1'b0;
  logic [8:0] Wr_Row = '0;
  logic       Rd_Grant, Rd_Done, Wr_Grant, Wr_Done;
  logic       Mem_Start, Mem_Write, Busy, Timeout;
  logic [8:0] Mem_Row;

  // Controller model state
  logic       mem_done_m = 1'b1;
  logic       m_active = 1'b0;
  int         m_ctr = 0;
  logic       stuck = 1'b0;
  int         hi_delay = 150;

  int n_tests = 0;
  int n_fail  = 0;

  // Observation results
  int         m_start_hi, m_rd_done, m_wr_done, m_overlap, m_row_bad;
  logic       m_rd_seen, m_wr_seen, m_timeout;
  logic [8:0] m_exp_row;
  logic       m_exp_write;

  always #5 clk = ~clk;

  sdram_row_arbiter #(
    .START_CYCLES   (2),
    .MAX_READ_STREAK(4),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .CLK      (clk),
    .Reset_N  (Reset_N),
    .Rd_Req   (Rd_Req),
    .Rd_Row   (Rd_Row),
    .Rd_Grant (Rd_Grant),
    .Rd_Done  (Rd_Done),
    .Wr_Req   (Wr_Req),
    .Wr_Row   (Wr_Row),
    .Wr_Grant (Wr_Grant),
    .Wr_Done  (Wr_Done),
    .Mem_Start(Mem_Start),
    .Mem_Row  (Mem_Row),
    .Mem_Write(Mem_Write),
    .Mem_Done (mem_done_m),
    .Busy     (Busy),
    .Timeout  (Timeout)
  );

  // Controller: Done drops 2 cycles after start ends, rises hi_delay later.
  always @(posedge clk) begin
    if (Mem_Start) begin
      m_ctr    <= 0;
      m_active <= 1'b1;
    end else if (m_active) begin
      m_ctr <= m_ctr + 1;
      if (m_ctr == 1) mem_done_m <= stuck;
      if (m_ctr == 1 + hi_delay) begin
        mem_done_m <= 1'b1;
        m_active   <= 1'b0;
      end
    end
  end

  // Watch one operation; drops the owner's Req on its Done.
  task automatic observe(input int max_cyc, input int drop_after);
    int gcyc;
    logic fin;
    gcyc = -1; fin = 1'b0;
    m_start_hi = 0; m_rd_done = 0; m_wr_done = 0; m_overlap = 0; m_row_bad = 0;
    m_rd_seen = 1'b0; m_wr_seen = 1'b0; m_timeout = 1'b1;
    for (int c = 0; c < max_cyc && !fin; c++) begin
      @(negedge clk);
      if (Mem_Start) m_start_hi++;
      if (Rd_Grant) m_rd_seen = 1'b1;
      if (Wr_Grant) m_wr_seen = 1'b1;
      if (Rd_Grant && Wr_Grant) m_overlap++;
      if ((Rd_Grant || Wr_Grant) && (Mem_Row !== m_exp_row || Mem_Write !== m_exp_write))
        m_row_bad++;
      if (gcyc >= 0) gcyc++;
      else if (Rd_Grant || Wr_Grant) gcyc = 0;
      if (drop_after > 0 && gcyc == drop_after) begin
        Rd_Req = 1'b0;
        Wr_Req = 1'b0;
      end
      if (Rd_Done) begin m_rd_done++; Rd_Req = 1'b0; end
      if (Wr_Done) begin m_wr_done++; Wr_Req = 1'b0; end
      if ((m_rd_done + m_wr_done) > 0 && !Busy) begin
        fin = 1'b1;
        m_timeout = 1'b0;
      end
    end
  endtask

  task automatic test_reset();
    logic [16:0] outs;
    repeat (3) @(negedge clk);
    outs = {Rd_Grant, Rd_Done, Wr_Grant, Wr_Done, Mem_Start, Mem_Row, Mem_Write, Busy, Timeout};
    n_tests++;
    if (outs !== 17'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h expected %h", outs, 17'h0);
    end
    Reset_N = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single_read();
    hi_delay = 150;
    Rd_Row = 9'h0A5; Rd_Req = 1'b1; Wr_Req = 1'b0;
    m_exp_row = 9'h0A5; m_exp_write = 1'b0;
    observe(400, 0);
    n_tests++;
    if (m_timeout !== 1'b0) begin n_fail++; $display("FAIL read_complete: got timeout=%0d expected 0", m_timeout); end
    n_tests++;
    if (m_start_hi != 2) begin n_fail++; $display("FAIL read_start_len: got %0d expected 2", m_start_hi); end
    n_tests++;
    if (m_rd_done != 1) begin n_fail++; $display("FAIL read_done_pulses: got %0d expected 1", m_rd_done); end
    n_tests++;
    if (m_wr_seen !== 1'b0) begin n_fail++; $display("FAIL read_no_wr_grant: got %0d expected 0", m_wr_seen); end
    n_tests++;
    if (m_row_bad != 0) begin n_fail++; $display("FAIL read_row_dir: got %0d bad cycles expected 0", m_row_bad); end
    n_tests++;
    if (!m_rd_seen) begin n_fail++; $display("FAIL read_grant_seen: got %0d expected 1", m_rd_seen); end
  endtask

  task automatic test_streak();
    logic [9:0] order;
    int n, overlap;
    logic prev_r, prev_w, fin;
    hi_delay = 3;
    order = '0; n = 0; overlap = 0; prev_r = 1'b0; prev_w = 1'b0;
    Rd_Row = 9'h011; Wr_Row = 9'h122;
    Rd_Req = 1'b1; Wr_Req = 1'b1;
    for (int c = 0; c < 1500 && n < 10; c++) begin
      @(negedge clk);
      if (Rd_Grant && Wr_Grant) overlap++;
      if (Rd_Grant && !prev_r) begin order[n] = 1'b0; n++; end
      else if (Wr_Grant && !prev_w) begin order[n] = 1'b1; n++; end
      prev_r = Rd_Grant; prev_w = Wr_Grant;
    end
    Rd_Req = 1'b0; Wr_Req = 1'b0;
    fin = 1'b0;
    for (int c = 0; c < 200 && !fin; c++) begin
      @(negedge clk);
      if (Rd_Grant && Wr_Grant) overlap++;
      if (!Busy) fin = 1'b1;
    end
    n_tests++;
    if (n != 10 || !fin) begin n_fail++; $display("FAIL streak_progress: got %0d grants idle=%0d expected 10 grants idle=1", n, fin); end
    n_tests++;
    if (order !== 10'b1000010000) begin n_fail++; $display("FAIL streak_order: got %b expected %b (bit0 first, 1=W)", order, 10'b1000010000); end
    n_tests++;
    if (overlap != 0) begin n_fail++; $display("FAIL streak_overlap: got %0d expected 0", overlap); end
  endtask

  task automatic test_write_drop();
    hi_delay = 8;
    Wr_Row = 9'h1FF; Wr_Req = 1'b1; Rd_Req = 1'b0;
    m_exp_row = 9'h1FF; m_exp_write = 1'b1;
    observe(300, 5);
    n_tests++;
    if (m_timeout !== 1'b0 || m_wr_done != 1) begin n_fail++; $display("FAIL write_done: got %0d pulses timeout=%0d expected 1 pulse", m_wr_done, m_timeout); end
    n_tests++;
    if (m_row_bad != 0) begin n_fail++; $display("FAIL write_row_hold: got %0d bad cycles expected 0", m_row_bad); end
    n_tests++;
    if (m_rd_seen !== 1'b0 || m_rd_done != 0) begin n_fail++; $display("FAIL write_no_read: got grant=%0d done=%0d expected 0 0", m_rd_seen, m_rd_done); end
  endtask

  task automatic test_wr_during_read();
    int d, g, overlap;
    logic [9:0] at_grant;
    logic fin;
    hi_delay = 5;
    d = -1; g = -1; overlap = 0; fin = 1'b0; at_grant = '0;
    Rd_Row = 9'h055; Rd_Req = 1'b1; Wr_Req = 1'b0;
    for (int c = 1; c < 600 && !fin; c++) begin
      @(negedge clk);
      if (Rd_Grant && Wr_Grant) overlap++;
      if (c == 4) begin Wr_Row = 9'h033; Wr_Req = 1'b1; end
      if (Rd_Done) begin d = c; Rd_Req = 1'b0; end
      if (Wr_Grant && g < 0) begin g = c; at_grant = {Mem_Write, Mem_Row}; end
      if (Wr_Done) Wr_Req = 1'b0;
      if (g > 0 && !Busy) fin = 1'b1;
    end
    n_tests++;
    if (d < 0 || g != d + 2) begin n_fail++; $display("FAIL wr_after_read_timing: got grant cycle %0d expected %0d", g, d + 2); end
    n_tests++;
    if (at_grant !== {1'b1, 9'h033}) begin n_fail++; $display("FAIL wr_after_read_row: got %h expected %h", at_grant, {1'b1, 9'h033}); end
    n_tests++;
    if (overlap != 0 || !fin) begin n_fail++; $display("FAIL wr_after_read_clean: got overlap=%0d idle=%0d expected 0 1", overlap, fin); end
  endtask

  task automatic test_reset_mid();
    logic [16:0] outs;
    logic reached;
    int after_low;
    hi_delay = 150;
    reached = 1'b0; after_low = 0;
    Rd_Row = 9'h123; Rd_Req = 1'b1; Wr_Req = 1'b0;
    for (int c = 0; c < 100 && !reached; c++) begin
      @(negedge clk);
      if (Busy && !Mem_Start && !mem_done_m) after_low++;
      if (after_low == 3) reached = 1'b1;
    end
    n_tests++;
    if (!reached) begin n_fail++; $display("FAIL reset_mid_reach_wait_high: got %0d expected 1", reached); end
    #2 Reset_N = 1'b0;
    #1 outs = {Rd_Grant, Rd_Done, Wr_Grant, Wr_Done, Mem_Start, Mem_Row, Mem_Write, Busy, Timeout};
    n_tests++;
    if (outs !== 17'h0) begin n_fail++; $display("FAIL reset_mid_async: got %h expected %h", outs, 17'h0); end
    hi_delay = 10;
    @(negedge clk);
    Reset_N = 1'b1;
    m_exp_row = 9'h123; m_exp_write = 1'b0;
    observe(300, 0);
    n_tests++;
    if (m_start_hi != 2) begin n_fail++; $display("FAIL reset_mid_restart: got %0d start cycles expected 2", m_start_hi); end
    n_tests++;
    if (m_timeout !== 1'b0 || m_rd_done != 1 || m_row_bad != 0) begin
      n_fail++;
      $display("FAIL reset_mid_complete: got done=%0d bad=%0d timeout=%0d expected 1 0 0", m_rd_done, m_row_bad, m_timeout);
    end
  endtask

  task automatic test_stuck_done();
    int k, done_k;
    logic started, fin;
    stuck = 1'b1; hi_delay = 5;
    k = 0; done_k = -1; started = 1'b0; fin = 1'b0;
    Rd_Row = 9'h0F0; Rd_Req = 1'b1; Wr_Req = 1'b0;
    for (int c = 0; c < 80 && !fin; c++) begin
      @(negedge clk);
      if (Mem_Start) started = 1'b1;
      else if (started) k++;
      if (Rd_Done && done_k < 0) begin done_k = k; Rd_Req = 1'b0; end
`ifdef ARB_WATCHDOG_EN
      if (done_k > 0 && !Busy) fin = 1'b1;
`endif
    end
`ifdef ARB_WATCHDOG_EN
    n_tests++;
    if (done_k < 17 || done_k > 18) begin n_fail++; $display("FAIL watchdog_done_time: got %0d expected 17..18", done_k); end
    n_tests++;
    if (Timeout !== 1'b1 || Busy !== 1'b0) begin n_fail++; $display("FAIL watchdog_flag: got timeout=%0d busy=%0d expected 1 0", Timeout, Busy); end
`else
    n_tests++;
    if (done_k != -1) begin n_fail++; $display("FAIL stuck_no_done: got done at %0d expected none", done_k); end
    n_tests++;
    if (Busy !== 1'b1 || Rd_Grant !== 1'b1 || Timeout !== 1'b0) begin
      n_fail++;
      $display("FAIL stuck_waiting: got busy=%0d grant=%0d timeout=%0d expected 1 1 0", Busy, Rd_Grant, Timeout);
    end
    Rd_Req = 1'b0;
    Reset_N = 1'b0;
    @(negedge clk);
    Reset_N = 1'b1;
    @(negedge clk);
    n_tests++;
    if (Busy !== 1'b0 || Rd_Grant !== 1'b0) begin n_fail++; $display("FAIL stuck_recover: got busy=%0d grant=%0d expected 0 0", Busy, Rd_Grant); end
`endif
    stuck = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_streak();
    test_write_drop();
    test_wr_during_read();
    test_reset_mid();
    test_stuck_done();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sdram_row_arbiter.md
Name: sdram_row_arbiter

Overview:
- Shares the single SDRAM row-burst memory controller between two requesters: the display read path and the frame write path.
- Latches the winning request and issues the controller's start/reset pulse with the row and direction.
- Tracks the controller's Done level to detect completion, then returns a one-cycle completion strobe to the owner.
- The 1696-bit In/Out data buses stay owned by the requesters; this block only drives the control signals.

Parameters:
- START_CYCLES, 2, number of CLK cycles Mem_Start is held high (covers the controller's negedge sampling).
- MAX_READ_STREAK, 4, consecutive read grants allowed while a write is pending before the write is forced.
- TIMEOUT_CYCLES, 1023, watchdog limit in CLK cycles per operation; width is clog2(TIMEOUT_CYCLES+1).

Ports:
- CLK  in  1  system clock; all state updates on rising edge.
- Reset_N  in  1  asynchronous active-low reset.
- Rd_Req  in  1  display read request; hold high until Rd_Done.
- Rd_Row  in  9  row for read; sampled at grant.
- Rd_Grant  out  1  high while the read owns the controller.
- Rd_Done  out  1  one-cycle pulse: read data valid on controller Out.
- Wr_Req  in  1  frame write request; hold high until Wr_Done.
- Wr_Row  in  9  row for write; sampled at grant.
- Wr_Grant  out  1  high while the write owns the controller (In mux select).
- Wr_Done  out  1  one-cycle pulse: write finished.
- Mem_Start  out  1  drives controller Reset.
- Mem_Row  out  9  drives controller RowAddress.
- Mem_Write  out  1  drives controller Write.
- Mem_Done  in  1  controller Done level.
- Busy  out  1  high in any state except IDLE.
- Timeout  out  1  sticky error flag; cleared only by reset.

Behaviour:
- Reset (async, Reset_N=0): all outputs 0, state IDLE, streak counter 0, watchdog counter 0.
- Reset mid-operation aborts immediately with no Done pulse. The controller continues on its own; the next grant restarts it.
- States:
  - IDLE -> START when any Req is high.
  - START -> WAIT_LOW after START_CYCLES cycles.
  - WAIT_LOW -> WAIT_HIGH on Mem_Done=0.
  - WAIT_HIGH -> FINISH on Mem_Done=1.
  - FINISH -> IDLE after 1 cycle.
- Arbitration (IDLE only):
  - Only one requester high: it wins.
  - Both high: read wins, unless the streak counter equals MAX_READ_STREAK, in which case write wins.
  - Streak counter: +1 on each read grant made while Wr_Req=1, saturating; cleared on any write grant; cleared on a read grant with Wr_Req=0.
- On grant, the edge leaving IDLE:
  - Latch Mem_Row := winner's Row; Mem_Write := 1 for write, 0 for read.
  - Set the winner's Grant.
  - Mem_Start = 1 for exactly START_CYCLES cycles.
- Mem_Row and Mem_Write stay stable from grant until return to IDLE.
- The WAIT_LOW stage exists because controller Done stays high from the previous operation until the start is seen. Completion requires observing a 0 then a 1.
- FINISH: the owner's Done = 1 for exactly one cycle and its Grant is still high. Both drop on the transition to IDLE.
- Earliest re-grant is the cycle after FINISH, giving a minimum of 1 IDLE cycle between operations.
- A Req deasserted after grant is ignored; the operation completes and the Done pulse is still issued.
- A Req raised during Busy waits; no queueing beyond the level-held Req.
- Rd_Grant and Wr_Grant are never both high. Rd_Done and Wr_Done are never both high.

Optional Feature:
- Macro ARB_WATCHDOG_EN.
- Defined:
  - The watchdog counter clears on entry to START and counts every cycle in WAIT_LOW and WAIT_HIGH.
  - On reaching TIMEOUT_CYCLES: Timeout := 1 (sticky), the owner's Done pulses in the following FINISH cycle, and the block returns to IDLE.
  - Ownership is released so the other requester is not blocked forever.
- Undefined:
  - No counter; Timeout is tied to 0.
  - WAIT states wait indefinitely.

Test Plan:
- Rd_Req=1 with Rd_Row=9'h0A5 and Wr_Req=0; a controller model drops Done 2 cycles after start and raises it 150 cycles later.
  -> Mem_Row=0x0A5, Mem_Write=0, Mem_Start high 2 cycles, Rd_Done pulses once, Wr_Grant never asserts.
- Rd_Req and Wr_Req both held high continuously.
  -> Grant order is R,R,R,R,W,R,R,R,R,W; grants never overlap.
- Wr_Req=1 with Wr_Row=9'h1FF; Wr_Req dropped 5 cycles after grant.
  -> Operation completes, Wr_Done pulses once, Mem_Row holds 0x1FF throughout.
- Mem_Done held 1 continuously after Mem_Start.
  -> Block stays in WAIT_LOW with no Done pulse.
  -> With ARB_WATCHDOG_EN and TIMEOUT_CYCLES=16: Timeout=1 and Done pulses 17–18 cycles after START exits.
- Reset_N pulled low during WAIT_HIGH.
  -> All outputs 0 asynchronously. After release with Rd_Req=1, a new grant starts with a fresh Mem_Start.
- Wr_Req rises during a read operation.
  -> Wr_Grant asserts the cycle after IDLE is entered following Rd_Done.
